// File: rtl/ip_header_insert_pkg.sv
// Shared types and constants for the IPv4 header inserter.
// The checksum fold lives here so the adder and any future users agree on it.
package ip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        HDR,
        PAYLOAD
    } state_t;

    localparam int          IP_HDR_LEN   = 20;
    localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;

    // Two end-around-carry folds always suffice for a sum of at most 16 words.
    function automatic logic [15:0] ip_csum_fold(input logic [19:0] sum);
        logic [19:0] fold1;
        logic [19:0] fold2;
        fold1 = {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
        fold2 = {4'd0, fold1[15:0]} + {16'd0, fold1[19:16]};
        return ~fold2[15:0];
    endfunction

endpackage

// File: rtl/ip_header_insert_hdr_csum.sv
// Combinational IPv4 header checksum over the ten header words.
// The checksum word itself is summed as zero.
module ip_hdr_csum
    import ip_pkg::*;
#(
    parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
    parameter logic [31:0] DST_IP   = 32'hC0A80164,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [7:0]  PROTOCOL = 8'd17
) (
    input  logic [15:0] total,
    input  logic [15:0] ident,
    output logic [15:0] csum
);

    logic [15:0] words [10];
    logic [19:0] sum;

    assign words[0] = {IPV4_VER_IHL, 8'h00};
    assign words[1] = total;
    assign words[2] = ident;
    assign words[3] = IP_FLAGS_DF;
    assign words[4] = {TTL, PROTOCOL};
    assign words[5] = 16'h0000;
    assign words[6] = SRC_IP[31:16];
    assign words[7] = SRC_IP[15:0];
    assign words[8] = DST_IP[31:16];
    assign words[9] = DST_IP[15:0];

    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'd0, words[i]};
        end
    end

    assign csum = ip_csum_fold(sum);

endmodule

// File: rtl/ip_header_insert.sv
// Prepends a 20-byte IPv4 header to each buffered UDP datagram, one length word per packet.
// Header bytes come from registered fields; payload is passed straight through.
module ip_header_insert
    import ip_pkg::*;
#(
    parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
    parameter logic [31:0] DST_IP   = 32'hC0A80164,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [7:0]  PROTOCOL = 8'd17
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        length_tvalid,
    output logic        length_tready,
    input  logic [15:0] length_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        len_err
);

    state_t      state_reg;
    logic [4:0]  idx_reg;
    logic [15:0] ident_reg;
    logic [15:0] total_reg;
    logic [15:0] csum_reg;
    logic        len_err_reg;
    logic        ready_reg;

    logic [16:0] total_next;
    logic [15:0] csum_next;
    logic        len_hs;
    logic [7:0]  hdr_bytes [IP_HDR_LEN];

    // length_tdata is the byte count minus one, so +1 for the payload and +20 for the header.
    assign total_next = {1'b0, length_tdata} + 17'd21;
    assign len_hs     = length_tvalid & ready_reg & (state_reg == IDLE);

    ip_hdr_csum #(
        .SRC_IP   (SRC_IP),
        .DST_IP   (DST_IP),
        .TTL      (TTL),
        .PROTOCOL (PROTOCOL)
    ) u_csum (
        .total (total_reg),
        .ident (ident_reg),
        .csum  (csum_next)
    );

    assign hdr_bytes[0]  = IPV4_VER_IHL;
    assign hdr_bytes[1]  = 8'h00;
    assign hdr_bytes[2]  = total_reg[15:8];
    assign hdr_bytes[3]  = total_reg[7:0];
    assign hdr_bytes[4]  = ident_reg[15:8];
    assign hdr_bytes[5]  = ident_reg[7:0];
    assign hdr_bytes[6]  = IP_FLAGS_DF[15:8];
    assign hdr_bytes[7]  = IP_FLAGS_DF[7:0];
    assign hdr_bytes[8]  = TTL;
    assign hdr_bytes[9]  = PROTOCOL;
    assign hdr_bytes[10] = csum_reg[15:8];
    assign hdr_bytes[11] = csum_reg[7:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_addr
            assign hdr_bytes[12 + gi] = SRC_IP[31 - 8*gi -: 8];
            assign hdr_bytes[16 + gi] = DST_IP[31 - 8*gi -: 8];
        end
    endgenerate

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        s_tready = 1'b0;
        case (state_reg)
            HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = hdr_bytes[idx_reg];
            end
            PAYLOAD: begin
                m_tvalid = s_tvalid;
                s_tready = m_tready;
                m_tdata  = s_tdata;
                m_tlast  = s_tlast;
            end
            default: ;
        endcase
    end

    assign length_tready = ready_reg;
    assign len_err       = len_err_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            ident_reg   <= '0;
            total_reg   <= '0;
            csum_reg    <= '0;
            len_err_reg <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (len_hs) begin
                        total_reg <= total_next[15:0];
                        if (total_next[16]) begin
                            len_err_reg <= 1'b1;
                        end
                        ready_reg <= 1'b0;
                        state_reg <= CSUM;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                CSUM: begin
                    csum_reg  <= csum_next;
                    idx_reg   <= '0;
                    state_reg <= HDR;
                end
                HDR: begin
                    if (m_tready) begin
                        if (idx_reg == 5'(IP_HDR_LEN - 1)) begin
                            idx_reg   <= '0;
                            state_reg <= PAYLOAD;
                        end else begin
                            idx_reg <= idx_reg + 5'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    // tlast alone ends the packet; the latched length is never cross-checked.
                    if (s_tvalid && m_tready && s_tlast) begin
                        ident_reg <= ident_reg + 16'd1;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_insert.sv
// Randomised bench for ip_header_insert with a byte-list reference model of each IPv4 packet.
// Inputs change 1 ns after the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_ip_header_insert;

    localparam logic [31:0] SRC     = 32'hC0A8010A;
    localparam logic [31:0] DST     = 32'hC0A80164;
    localparam logic [7:0]  TTL_B   = 8'd64;
    localparam logic [7:0]  PROTO_B = 8'd17;

    logic        clk;
    logic        resetn;
    logic        length_tvalid;
    logic        length_tready;
    logic [15:0] length_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        len_err;

    ip_header_insert dut (
        .clk           (clk),
        .resetn        (resetn),
        .length_tvalid (length_tvalid),
        .length_tready (length_tready),
        .length_tdata  (length_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .len_err       (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [7:0]  basic_pkt [28] = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00,
                                    8'h40, 8'h11, 8'hB7, 8'h12, 8'hC0, 8'hA8, 8'h01, 8'h0A,
                                    8'hC0, 8'hA8, 8'h01, 8'h64, 8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0]  pay [$];
    logic [7:0]  got_d [$];
    bit          got_l [$];
    logic [7:0]  exp_d [$];
    logic [15:0] model_ident;
    int hs_cyc, first_cyc, last_cyc, stall_bad, early_bad;

    // Expected packet: header from the field rules, checksum by repeated end-around carry.
    function automatic void model_pkt(input logic [15:0] lw, input logic [15:0] id);
        logic [16:0] tot17;
        logic [15:0] tot;
        logic [15:0] ck;
        int unsigned sum;
        logic [7:0]  hdr [20];
        tot17 = {1'b0, lw} + 17'd21;
        tot   = tot17[15:0];
        sum   = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'({TTL_B, PROTO_B})
              + 32'(SRC[31:16]) + 32'(SRC[15:0]) + 32'(DST[31:16]) + 32'(DST[15:0]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        ck = ~16'(sum);
        hdr = '{8'h45, 8'h00, tot[15:8], tot[7:0], id[15:8], id[7:0], 8'h40, 8'h00, TTL_B, PROTO_B,
                ck[15:8], ck[7:0], SRC[31:24], SRC[23:16], SRC[15:8], SRC[7:0],
                DST[31:24], DST[23:16], DST[15:8], DST[7:0]};
        exp_d.delete();
        foreach (hdr[i]) exp_d.push_back(hdr[i]);
        foreach (pay[i]) exp_d.push_back(pay[i]);
    endfunction

    function automatic void load_basic_payload();
        pay.delete();
        for (int i = 1; i <= 8; i++) pay.push_back(8'(i));
    endfunction

    function automatic void load_basic_expected();
        exp_d.delete();
        foreach (basic_pkt[i]) exp_d.push_back(basic_pkt[i]);
    endfunction

    function automatic void fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endfunction

    // Index of the first byte (or tlast flag) that disagrees with exp_d, -1 when all agree.
    function automatic int first_diff();
        int n;
        n = (got_d.size() > exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_d.size() || i >= exp_d.size()) return i;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) return i;
        end
        return -1;
    endfunction

    function automatic logic [8:0] got_at(input int i);
        if (i < 0 || i >= got_d.size()) return 9'hxxx;
        return {got_l[i], got_d[i]};
    endfunction

    function automatic logic [8:0] exp_at(input int i);
        if (i < 0 || i >= exp_d.size()) return 9'hxxx;
        return {i == exp_d.size() - 1, exp_d[i]};
    endfunction

    task automatic idle(input int n);
        @(posedge clk); #1;
        length_tvalid = 1'b0;
        s_tvalid      = 1'b0;
        s_tlast       = 1'b0;
        m_tready      = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    // Drives one length word plus the bytes in pay, collecting output until m_tlast or a cycle budget.
    task automatic run_pkt(input logic [15:0] lw, input int early, input bit bp, input int abort_at);
        int   pi;
        int   hdr_seen;
        bit   len_done;
        bit   hold;
        bit   done;
        bit   prev_stall;
        logic [7:0] prev_d;
        pi = 0; hdr_seen = 0; len_done = 0; hold = 0; done = 0; prev_stall = 0; prev_d = 8'h00;
        got_d.delete(); got_l.delete();
        hs_cyc = -1; first_cyc = -1; last_cyc = -1; stall_bad = 0; early_bad = 0;
        for (int it = 0; it < 800 && !done; it++) begin
            @(posedge clk); #1;
            length_tvalid = !len_done && (it >= early);
            length_tdata  = lw;
            if (!hold) s_tvalid = (pi < pay.size()) && (!bp || $urandom_range(0, 3) != 0);
            s_tdata  = (pi < pay.size()) ? pay[pi] : 8'h00;
            s_tlast  = (pi == pay.size() - 1);
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at >= 0 && pi == abort_at) begin
                resetn = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            if (length_tvalid && length_tready) begin
                len_done = 1;
                hs_cyc   = cyc;
            end
            if (m_tvalid && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && m_tdata !== prev_d) stall_bad++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            if (s_tready && hdr_seen < 20) early_bad++;
            if (s_tvalid && s_tready) pi++;
            hold = s_tvalid && !s_tready;
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_l.push_back(m_tlast);
                hdr_seen++;
                last_cyc = cyc;
                if (m_tlast) done = 1;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        length_tvalid = 1'b0; length_tdata = 16'h0000;
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        model_ident = 16'h0000;
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset_m_tlast: got %b, required 0", m_tlast); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b, required 0", s_tready); end
        tests++; if (length_tready !== 1'b0) begin fails++; $display("FAIL reset_length_tready: got %b, required 0", length_tready); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %b, required 0", len_err); end
        @(negedge clk);
        tests++; if (length_tready !== 1'b1) begin fails++; $display("FAIL reset_idle_ready: got %b, required 1", length_tready); end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_basic();
        int d;
        load_basic_payload();
        load_basic_expected();
        run_pkt(16'd7, 0, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL basic_bytes: byte %0d got %h, required %h (%0d of %0d bytes)", d, got_at(d), exp_at(d), got_d.size(), exp_d.size()); end
        tests++; if (first_cyc - hs_cyc !== 2) begin fails++; $display("FAIL basic_latency: got %0d cycles, required 2", first_cyc - hs_cyc); end
        tests++; if (last_cyc - first_cyc !== 27) begin fails++; $display("FAIL basic_no_bubble: got span %0d, required 27", last_cyc - first_cyc); end
        model_ident = model_ident + 16'd1;
        $display("[TB] basic: %0d bytes out", got_d.size());
    endtask

    task automatic test_back_to_back();
        int d;
        int prev_last;
        int n;
        load_basic_payload();
        model_pkt(16'd7, model_ident);
        run_pkt(16'd7, 0, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL b2b_first: byte %0d got %h, required %h", d, got_at(d), exp_at(d)); end
        model_ident = model_ident + 16'd1;
        prev_last = last_cyc;
        n = $urandom_range(1, 16);
        fill_random(n);
        model_pkt(16'(n - 1), model_ident);
        run_pkt(16'(n - 1), 0, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL b2b_second: byte %0d got %h, required %h", d, got_at(d), exp_at(d)); end
        tests++; if (first_cyc - prev_last !== 3) begin fails++; $display("FAIL b2b_gap: got %0d cycles last-to-first, required 3", first_cyc - prev_last); end
        model_ident = model_ident + 16'd1;
        $display("[TB] back_to_back: second packet %0d payload bytes", n);
    endtask

    task automatic test_backpressure();
        int d;
        int n;
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                n = 8;
                load_basic_payload();
            end else begin
                n = $urandom_range(1, 16);
                fill_random(n);
            end
            model_pkt(16'(n - 1), model_ident);
            run_pkt(16'(n - 1), 0, 1, -1);
            d = first_diff();
            tests++; if (d != -1) begin fails++; $display("FAIL bp_bytes_%0d: byte %0d got %h, required %h", p, d, got_at(d), exp_at(d)); end
            tests++; if (stall_bad !== 0) begin fails++; $display("FAIL bp_stable_%0d: got %0d changes while stalled, required 0", p, stall_bad); end
            model_ident = model_ident + 16'd1;
            $display("[TB] backpressure %0d: %0d payload bytes", p, n);
        end
        idle(1);
    endtask

    task automatic test_early_payload();
        int d;
        int n;
        n = $urandom_range(2, 16);
        fill_random(n);
        model_pkt(16'(n - 1), model_ident);
        run_pkt(16'(n - 1), 10, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL early_bytes: byte %0d got %h, required %h", d, got_at(d), exp_at(d)); end
        tests++; if (early_bad !== 0) begin fails++; $display("FAIL early_s_tready: got %0d cycles ready before header end, required 0", early_bad); end
        model_ident = model_ident + 16'd1;
        $display("[TB] early_payload: %0d payload bytes", n);
        idle(1);
    endtask

    task automatic test_overflow();
        int d;
        fill_random(3);
        model_pkt(16'hFFFF, model_ident);
        run_pkt(16'hFFFF, 0, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL overflow_bytes: byte %0d got %h, required %h", d, got_at(d), exp_at(d)); end
        tests++; if (len_err !== 1'b1) begin fails++; $display("FAIL overflow_len_err: got %b, required 1", len_err); end
        model_ident = model_ident + 16'd1;
        $display("[TB] overflow: len_err=%b", len_err);
        idle(1);
    endtask

    task automatic test_ident_wrap();
        int d;
        int n;
        @(negedge clk);
        force dut.ident_reg = 16'hFFFF;
        @(negedge clk);
        release dut.ident_reg;
        model_ident = 16'hFFFF;
        for (int p = 0; p < 2; p++) begin
            n = $urandom_range(1, 12);
            fill_random(n);
            model_pkt(16'(n - 1), model_ident);
            run_pkt(16'(n - 1), 0, 0, -1);
            d = first_diff();
            tests++; if (d != -1) begin fails++; $display("FAIL wrap_bytes_%0d: byte %0d got %h, required %h", p, d, got_at(d), exp_at(d)); end
            model_ident = model_ident + 16'd1;
            $display("[TB] ident_wrap %0d: %0d payload bytes", p, n);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int d;
        load_basic_payload();
        run_pkt(16'd7, 0, 0, 2);
        @(posedge clk); #1;
        resetn = 1'b1;
        length_tvalid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        model_ident = 16'h0000;
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midreset_m_tvalid: got %b, required 0", m_tvalid); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL midreset_len_err: got %b, required 0", len_err); end
        load_basic_payload();
        load_basic_expected();
        run_pkt(16'd7, 0, 0, -1);
        d = first_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL midreset_next: byte %0d got %h, required %h", d, got_at(d), exp_at(d)); end
        $display("[TB] reset_mid: next packet %0d bytes", got_d.size());
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_early_payload();
        test_overflow();
        test_ident_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
